// File: rtl/pixel_pkg.sv
// Shared types and sizing for the pixel row scheduler: pixel/row types,
// source tags and scheduler states.
package pixel_pkg;
  localparam int PIXEL_W = 6;
  localparam int ROW_LEN = 8;  // power of 2, at least 2
  localparam int CNT_W   = $clog2(ROW_LEN);

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef pixel_t [ROW_LEN-1:0] pixel_row_t;

  typedef enum logic {SRC_BG = 1'b0, SRC_SPR = 1'b1} src_t;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} sched_state_t;
endpackage

// File: rtl/row_shifter.sv
// Holds one latched tile row and walks it from slot ROW_LEN-1 down to slot 0.
// With SPRITE_XFLIP_EN defined, a flagged row is stored reversed on load.
module row_shifter
  import pixel_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       clear,
  input  logic       load,
  input  pixel_row_t load_row,
  input  logic       load_flip,
  input  logic       advance,
  output pixel_t     pixel,
  output logic       last_pixel
);
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] slot;
  pixel_row_t       row_q;
  pixel_row_t       load_val;

`ifdef SPRITE_XFLIP_EN
  always_comb begin
    load_val = load_row;
    if (load_flip) begin
      for (int i = 0; i < ROW_LEN; i++) load_val[i] = load_row[ROW_LEN-1-i];
    end
  end
`else
  logic unused_flip;
  assign unused_flip = load_flip;
  assign load_val    = load_row;
`endif

  // Loading restarts the walk, so a row latched on the final write needs no bubble.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      row_q <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      row_q <= load_val;
      count <= '0;
    end else if (advance) begin
      count <= count + CNT_W'(1);
    end
  end

  assign slot       = CNT_W'(ROW_LEN - 1) - count;
  assign pixel      = row_q[slot];
  assign last_pixel = (count == CNT_W'(ROW_LEN - 1));
endmodule

// File: rtl/pixel_row_scheduler.sv
// Arbitrates background and sprite row fetchers (sprite wins) and serializes the
// granted row into the pixel FIFO, one pixel per cycle. Macro: SPRITE_XFLIP_EN.
module pixel_row_scheduler
  import pixel_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       flush_in,
  input  logic       bg_req_in,
  input  pixel_row_t bg_row_in,
  output logic       bg_ack_out,
  input  logic       spr_req_in,
  input  pixel_row_t spr_row_in,
  input  logic       spr_flip_in,
  output logic       spr_ack_out,
  input  logic       fifo_full_in,
  output logic       fifo_wr_out,
  output pixel_t     fifo_data_out,
  output logic       fifo_src_out,
  output logic       busy_out,
  output logic       row_done_out
);
  // Handshakes: a requester holds *_req_in with its row stable until it sees
  // the one-cycle *_ack_out; a pixel moves on any edge where fifo_wr_out is 1.
  sched_state_t state, next_state;
  src_t         src_q;
  logic         grant_bg, grant_spr, load, wr, last_pixel;
  pixel_t       shift_pixel, last_data;
  pixel_row_t   load_row;

  always_comb begin
    next_state = state;
    grant_bg   = 1'b0;
    grant_spr  = 1'b0;
    wr         = 1'b0;
    case (state)
      IDLE: begin
        grant_spr = spr_req_in & ~flush_in;
        grant_bg  = bg_req_in & ~spr_req_in & ~flush_in;
        if (grant_spr || grant_bg) next_state = SHIFT;
      end
      SHIFT: begin
        wr = ~fifo_full_in & ~flush_in;
        // Requests are only looked at again on the final write of a row.
        if (wr && last_pixel) begin
          grant_spr = spr_req_in;
          grant_bg  = bg_req_in & ~spr_req_in;
          if (!(spr_req_in || bg_req_in)) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (flush_in) next_state = IDLE;
  end

  assign load     = grant_spr | grant_bg;
  assign load_row = grant_spr ? spr_row_in : bg_row_in;

  row_shifter u_row_shifter (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clear      (flush_in),
    .load       (load),
    .load_row   (load_row),
    .load_flip  (grant_spr & spr_flip_in),
    .advance    (wr),
    .pixel      (shift_pixel),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      src_q        <= SRC_BG;
      bg_ack_out   <= 1'b0;
      spr_ack_out  <= 1'b0;
      row_done_out <= 1'b0;
      last_data    <= '0;
    end else begin
      state        <= next_state;
      bg_ack_out   <= grant_bg;
      spr_ack_out  <= grant_spr;
      row_done_out <= wr & last_pixel;
      if (load) src_q <= grant_spr ? SRC_SPR : SRC_BG;
      if (wr) last_data <= shift_pixel;
    end
  end

  // Outside SHIFT the data bus keeps showing the last pixel actually written.
  assign fifo_wr_out   = wr;
  assign fifo_data_out = (state == SHIFT) ? shift_pixel : last_data;
  assign fifo_src_out  = src_q;
  assign busy_out      = (state == SHIFT);
endmodule

// File: tb/tb_pixel_row_scheduler.sv
// Directed bench for pixel_row_scheduler: per-cycle handshake checks plus a
// scoreboard of expected {src, pixel} writes.
module tb_pixel_row_scheduler;
  import pixel_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in, flush_in, bg_req_in, spr_req_in, spr_flip_in, fifo_full_in;
  pixel_row_t bg_row_in, spr_row_in;
  logic       bg_ack_out, spr_ack_out, fifo_wr_out, fifo_src_out, busy_out, row_done_out;
  pixel_t     fifo_data_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [PIXEL_W:0] exp_q[$];

  pixel_row_scheduler dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .flush_in      (flush_in),
    .bg_req_in     (bg_req_in),
    .bg_row_in     (bg_row_in),
    .bg_ack_out    (bg_ack_out),
    .spr_req_in    (spr_req_in),
    .spr_row_in    (spr_row_in),
    .spr_flip_in   (spr_flip_in),
    .spr_ack_out   (spr_ack_out),
    .fifo_full_in  (fifo_full_in),
    .fifo_wr_out   (fifo_wr_out),
    .fifo_data_out (fifo_data_out),
    .fifo_src_out  (fifo_src_out),
    .busy_out      (busy_out),
    .row_done_out  (row_done_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every write must match the next expected {src, pixel}.
  always @(negedge clk_in) begin
    if (!rst_in && fifo_wr_out) begin
      if (exp_q.size() == 0) check("extra_write", {25'd0, fifo_src_out, fifo_data_out}, 32'hFFFF_FFFF);
      else check("pixel", {25'd0, fifo_src_out, fifo_data_out}, {25'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic pixel_row_t make_row(input int base);
    pixel_row_t r;
    for (int i = 0; i < ROW_LEN; i++) r[i] = PIXEL_W'(base + ROW_LEN - 1 - i);
    return r;
  endfunction

  task automatic push_row(input pixel_row_t r, input logic src, input logic rev);
    for (int i = ROW_LEN - 1; i >= 0; i--)
      exp_q.push_back({src, rev ? r[ROW_LEN-1-i] : r[i]});
  endtask

  task automatic check_idle_outputs(input string tag, input pixel_t data);
    check({tag, "_wr"}, fifo_wr_out, 0);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_data"}, fifo_data_out, data);
  endtask

  // Single unstalled background row; called at posedge+1 with requests idle.
  task automatic run_bg(input pixel_row_t r);
    bg_row_in = r;
    bg_req_in = 1'b1;
    push_row(r, 1'b0, 1'b0);
    step();
    bg_req_in = 1'b0;
    #2;
    check("bg_ack", bg_ack_out, 1);
    check("bg_spr_ack", spr_ack_out, 0);
    check("bg_first_wr", fifo_wr_out, 1);
    check("bg_busy", busy_out, 1);
    check("bg_src", fifo_src_out, 0);
    for (int k = 1; k < ROW_LEN; k++) begin
      step(); #2;
      check("bg_wr", fifo_wr_out, 1);
      check("bg_ack_low", bg_ack_out, 0);
      check("bg_done_low", row_done_out, 0);
    end
    step(); #2;
    check("bg_row_done", row_done_out, 1);
    check_idle_outputs("bg_end", r[0]);
    step(); #2;
    check("bg_done_pulse", row_done_out, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pixel_row_t ra, rb;
    logic       flip_rev;
    rst_in = 1'b1; flush_in = 1'b0; bg_req_in = 1'b0; spr_req_in = 1'b0;
    spr_flip_in = 1'b0; fifo_full_in = 1'b0; bg_row_in = '0; spr_row_in = '0;
    step(); step(); #2;
    check("rst_ack_bg", bg_ack_out, 0);
    check("rst_ack_spr", spr_ack_out, 0);
    check("rst_done", row_done_out, 0);
    check("rst_src", fifo_src_out, 0);
    check_idle_outputs("rst", 0);
    step();
    rst_in = 1'b0;

    // Plain background row 01..08
    run_bg(make_row(8'h01));

    // Simultaneous requests: sprite first (flip flag set), background follows
    ra = make_row(8'h11);
    rb = make_row(8'h21);
`ifdef SPRITE_XFLIP_EN
    flip_rev = 1'b1;
`else
    flip_rev = 1'b0;
`endif
    push_row(ra, 1'b1, flip_rev);
    push_row(rb, 1'b0, 1'b0);
    spr_row_in = ra; bg_row_in = rb; spr_flip_in = 1'b1;
    spr_req_in = 1'b1; bg_req_in = 1'b1;
    step();
    spr_req_in = 1'b0; spr_flip_in = 1'b0;
    #2;
    check("arb_spr_ack", spr_ack_out, 1);
    check("arb_no_bg_ack", bg_ack_out, 0);
    check("arb_src_spr", fifo_src_out, 1);
    for (int k = 1; k < ROW_LEN; k++) begin
      step(); #2;
      check("arb_spr_wr", fifo_wr_out, 1);
      check("arb_bg_waits", bg_ack_out, 0);
    end
    step();
    bg_req_in = 1'b0;
    #2;
    check("arb_bg_ack", bg_ack_out, 1);
    check("arb_spr_done", row_done_out, 1);
    check("arb_no_bubble", fifo_wr_out, 1);
    check("arb_src_bg", fifo_src_out, 0);
    for (int k = 1; k < ROW_LEN; k++) begin
      step(); #2;
      check("arb_bg_wr", fifo_wr_out, 1);
    end
    step(); #2;
    check("arb_bg_done", row_done_out, 1);
    check_idle_outputs("arb_end", rb[0]);
    step();

    // Stall: FIFO full for 3 cycles after the 3rd pixel
    ra = make_row(8'h31);
    push_row(ra, 1'b0, 1'b0);
    bg_row_in = ra; bg_req_in = 1'b1;
    step();
    bg_req_in = 1'b0;
    for (int k = 1; k <= ROW_LEN + 3; k++) begin
      if (k > 1) step();
      fifo_full_in = (k >= 4 && k <= 6);
      #2;
      check("stall_wr", fifo_wr_out, !fifo_full_in);
      check("stall_done_low", row_done_out, 0);
      check("stall_busy", busy_out, 1);
      if (fifo_full_in) check("stall_data", fifo_data_out, ra[ROW_LEN-4]);
    end
    step(); #2;
    check("stall_done", row_done_out, 1);
    check_idle_outputs("stall_end", ra[0]);
    step();

    // Flush at count 4
    ra = make_row(8'h09);
    for (int i = ROW_LEN - 1; i >= ROW_LEN - 4; i--) exp_q.push_back({1'b0, ra[i]});
    bg_row_in = ra; bg_req_in = 1'b1;
    step();
    bg_req_in = 1'b0;
    for (int k = 2; k <= 4; k++) step();
    step();
    flush_in = 1'b1;
    bg_req_in = 1'b1;
    #2;
    check("flush_wr_low", fifo_wr_out, 0);
    step();
    flush_in = 1'b0;
    bg_req_in = 1'b0;
    #2;
    check_idle_outputs("flush_idle", ra[ROW_LEN-4]);
    check("flush_no_done", row_done_out, 0);
    check("flush_no_ack", bg_ack_out, 0);
    step(); #2;
    check("flush_no_done2", row_done_out, 0);
    run_bg(make_row(8'h19));

    // Asynchronous reset in the middle of a sprite row
    ra = make_row(8'h29);
    for (int i = ROW_LEN - 1; i >= ROW_LEN - 2; i--) exp_q.push_back({1'b1, ra[i]});
    spr_row_in = ra; spr_req_in = 1'b1;
    step();
    spr_req_in = 1'b0;
    step(); step(); #2;
    check("pre_rst_src", fifo_src_out, 1);
    #1;
    rst_in = 1'b1;
    #1;
    check("arst_wr", fifo_wr_out, 0);
    check("arst_data", fifo_data_out, 0);
    check("arst_busy", busy_out, 0);
    check("arst_src", fifo_src_out, 0);
    check("arst_acks", {bg_ack_out, spr_ack_out}, 0);
    check("arst_done", row_done_out, 0);
    step();
    rst_in = 1'b0;
    step(); #2;
    check("post_rst_done", row_done_out, 0);
    run_bg(make_row(8'h38));

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pixel_row_scheduler.md
Name: pixel_row_scheduler

Overview:
- Arbitrates between two tile-row producers feeding the PPU pixel FIFO: the background/window fetcher and the sprite fetcher.
- Latches the granted 8-pixel row and serializes it MSB-slot first, one pixel per cycle.
- Honours downstream FIFO backpressure.
- Sits between the fetchers and the pixel FIFO, replacing free-running per-row serialization with a sequenced, shared path.

Parameters:
- PIXEL_W, 6: bits per pixel (palette/colour index).
- ROW_LEN, 8: pixels per tile row; must be a power of 2 and at least 2.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- flush_in  input  1  synchronous abort (line end / mode change).
- bg_req_in  input  1  background row available.
- bg_row_in  input  ROW_LEN x PIXEL_W  background row; slot ROW_LEN-1 is leftmost.
- bg_ack_out  output  1  one-cycle pulse: background row latched.
- spr_req_in  input  1  sprite row available.
- spr_row_in  input  ROW_LEN x PIXEL_W  sprite row.
- spr_flip_in  input  1  sprite X-flip (used only with the optional feature).
- spr_ack_out  output  1  one-cycle pulse: sprite row latched.
- fifo_full_in  input  1  downstream FIFO full.
- fifo_wr_out  output  1  write strobe.
- fifo_data_out  output  PIXEL_W  pixel being written.
- fifo_src_out  output  1  source of current pixel: 0 = background, 1 = sprite.
- busy_out  output  1  high while in SHIFT.
- row_done_out  output  1  one-cycle pulse after the last pixel of a row is written.

Behaviour:
- Reset (async, rst_in=1):
  - state=IDLE, count=0, row register=0, src=0.
  - All outputs 0: acks, row_done_out, busy_out, fifo_src_out, fifo_data_out.
- States: IDLE and SHIFT.
- IDLE:
  - On a clock edge with any request, grant it. Sprite has fixed priority over background.
  - Latch the granted row and src, set count=0, go to SHIFT.
  - Registered ack pulse for the granted requester on the next cycle.
  - A requester must deassert or advance its request on seeing ack. A request held during the ack cycle is not re-granted while in SHIFT.
- SHIFT:
  - fifo_wr_out = !fifo_full_in (combinational). Write occurs when fifo_wr_out=1.
  - fifo_data_out = row[ROW_LEN-1-count], so pixel slot 7 goes out first.
  - On a write edge: count increments.
  - When count==ROW_LEN-1 and a write occurs:
    - count wraps to 0.
    - row_done_out pulses the next cycle.
    - If any request is present on that edge, latch the new row immediately (same priority rule), stay in SHIFT and pulse its ack. No bubble.
    - Otherwise go to IDLE.
- Full FIFO: count and state hold; fifo_data_out stays stable; no write.
- Outside SHIFT: fifo_wr_out=0; fifo_data_out holds its last value.
- Latency and throughput:
  - Request sampled at edge N gives first fifo_wr_out in cycle N+1.
  - An unstalled row completes in ROW_LEN cycles.
  - Back-to-back rows sustain 1 pixel/cycle.
- flush_in (priority below reset, above everything else):
  - Next edge: state=IDLE, count=0.
  - No ack and no row_done_out is generated.
  - fifo_wr_out is forced 0 in the flush cycle.
  - Requests present during flush are ignored for that edge.
- Async reset mid-row abandons the row; no completion pulse is produced.

Optional Feature:
- Macro: SPRITE_XFLIP_EN.
- Defined: when a sprite row is latched with spr_flip_in=1, slots are stored reversed, so slot 0 is emitted first. The flip is sampled only at grant time.
- Undefined: spr_flip_in is ignored; sprite rows are emitted in the same order as background rows.

Decomposition:
- Package pixel_pkg:
  - PIXEL_W and ROW_LEN constants.
  - pixel_t typedef, logic [PIXEL_W-1:0].
  - pixel_row_t typedef, pixel_t [ROW_LEN-1:0].
  - src_t enum {SRC_BG, SRC_SPR}.
  - sched_state_t enum {IDLE, SHIFT}.
- Sub-module row_shifter:
  - Holds the latched row, count, optional flip-on-load and pixel select.
  - Outputs last_pixel.
  - Parent keeps arbitration, the FSM and the handshakes.

Test Plan:
- Single BG row 0x01..0x08 in slots 7..0, FIFO never full -> fifo_data_out sequence 01,02,...,08 on 8 consecutive cycles starting cycle N+1; bg_ack_out at N+1; row_done_out one cycle after the 8th write; back to IDLE.
- bg_req_in and spr_req_in asserted together -> sprite row emitted first with fifo_src_out=1, spr_ack_out pulse, no bg_ack_out; background row follows with no bubble after the 8th sprite pixel.
- fifo_full_in high for 3 cycles after the 3rd pixel -> exactly 8 writes total, no duplicate or dropped pixel, fifo_data_out stable during the stall, row_done_out delayed 3 cycles.
- flush_in at count=4 -> fifo_wr_out=0 in that cycle, IDLE next, no row_done_out; the next request restarts at slot 7.
- rst_in asserted asynchronously mid-row (between edges) -> all outputs 0 immediately, count=0; a request after release behaves as in the first scenario.
- With SPRITE_XFLIP_EN, sprite row 0x11..0x18 in slots 7..0 with spr_flip_in=1 -> emitted 18,17,...,11; without the macro -> 11..18.
